// File: rtl/brdec_multi_ras.sv
// Fetch-1 branch predecode for a WAYS-wide fetch block with an internal
// circular return address stack. The first predicted-taken control transfer
// in the block is selected and registered for fetch 2.
// Build option: define BRDEC_COND_PRED_EN to use pred_taken_i for conditional
// branches; otherwise conditionals are static backward-taken/forward-not-taken.
module brdec_multi_ras #(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic [32*WAYS-1:0]   inst_i,
  input  logic [63:0]          pc_f1_i,
  input  logic [WAYS-1:0]      pred_taken_i,
  input  logic                 recover_i,
  input  logic [PTR_W-1:0]     recover_ptr_i,
  input  logic [PTR_W:0]       recover_cnt_i,
  output logic                 valid_o,
  output logic                 br_flag_o,
  output logic [2:0]           br_way_o,
  output logic [1:0]           br_typ_o,
  output logic [63:0]          br_tar_o,
  output logic [PTR_W-1:0]     ras_ptr_o,
  output logic [PTR_W:0]       ras_cnt_o
);

  typedef enum logic [1:0] {
    BR_COND      = 2'd0,
    BR_UNCOND    = 2'd1,
    BR_INDIR_PC  = 2'd2,
    BR_INDIR_RAS = 2'd3
  } br_typ_e;

  typedef enum logic [1:0] {
    RAS_NONE    = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_POPPUSH = 2'd3
  } ras_act_e;

  typedef struct packed {
    logic        taken;
    br_typ_e     typ;
    ras_act_e    act;
    logic [63:0] tar;
    logic [63:0] ret;
  } way_dec_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [63:0]      ras_stack [RAS_DEPTH];
  logic [PTR_W-1:0] tos;
  logic [PTR_W:0]   cnt;
  logic [63:0]      ras_top;
  logic [WAYS-1:0]  cond_take;
  way_dec_t         dec;
  way_dec_t         sel;
  logic [2:0]       sel_way;
  logic             sel_found;
  logic             accept;
  logic             ras_upd;
  logic [PTR_W-1:0] push_slot;
  logic             unused_inst;

  // Decode one instruction slot into its type, RAS action and target.
  function automatic way_dec_t decode_way(input logic [31:0] inst,
                                          input logic [63:0] wpc,
                                          input logic        cond_tk,
                                          input logic [63:0] top);
    way_dec_t d;
    d       = '0;
    d.typ   = BR_COND;
    d.act   = RAS_NONE;
    d.ret   = wpc + 64'd4;
    if (inst[31:29] == 3'b111) begin
      d.taken = cond_tk;
      d.typ   = BR_COND;
      d.tar   = d.ret + {{41{inst[20]}}, inst[20:0], 2'b00};
    end else if (inst[31:26] == 6'h30 || inst[31:26] == 6'h34) begin
      d.taken = 1'b1;
      d.typ   = BR_UNCOND;
      d.act   = (inst[31:26] == 6'h34) ? RAS_PUSH : RAS_NONE;
      d.tar   = d.ret + {{41{inst[20]}}, inst[20:0], 2'b00};
    end else if (inst[31:26] == 6'h1A) begin
      d.taken = 1'b1;
      case (inst[15:14])
        2'b00: begin
          d.typ = BR_INDIR_PC;
          d.tar = d.ret + {{48{inst[13]}}, inst[13:0], 2'b00};
        end
        2'b01: begin
          d.typ = BR_INDIR_PC;
          d.act = RAS_PUSH;
          d.tar = d.ret + {{48{inst[13]}}, inst[13:0], 2'b00};
        end
        2'b10: begin
          d.typ = BR_INDIR_RAS;
          d.act = RAS_POP;
          d.tar = top;
        end
        default: begin
          d.typ = BR_INDIR_RAS;
          d.act = RAS_POPPUSH;
          d.tar = top;
        end
      endcase
    end
    return d;
  endfunction

  assign ras_top   = ras_stack[tos];
  assign accept    = valid_i & ~stall_i & ~flush_i;
  assign ras_upd   = accept & sel.taken & ~recover_i;
  assign push_slot = tos + PTR_W'(1);

  // Per-way conditional direction: dynamic prediction or displacement sign.
  always_comb begin
    cond_take = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
`ifdef BRDEC_COND_PRED_EN
      cond_take[w] = pred_taken_i[w];
`else
      cond_take[w] = inst_i[32*w+20];
`endif
    end
  end

`ifndef BRDEC_COND_PRED_EN
  logic unused_pred;
  assign unused_pred = ^pred_taken_i;
`endif

  // Register bits [25:21] carry no predecode information.
  always_comb begin
    unused_inst = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      unused_inst = unused_inst ^ (^inst_i[32*w+21 +: 5]);
    end
  end

  // Decode all ways and keep the lowest-index taken one.
  always_comb begin
    dec       = '0;
    sel       = '0;
    sel_way   = '0;
    sel_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      dec = decode_way(inst_i[32*w +: 32], pc_f1_i + 64'(4*w), cond_take[w], ras_top);
      if (dec.taken && !sel_found) begin
        sel_found = 1'b1;
        sel       = dec;
        sel_way   = 3'(w);
      end
    end
  end

  // Output registers and RAS pointer/occupancy; recover overrides the block's RAS action.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      br_flag_o <= 1'b0;
      br_way_o  <= '0;
      br_typ_o  <= '0;
      br_tar_o  <= '0;
      ras_ptr_o <= '0;
      ras_cnt_o <= '0;
      tos       <= '0;
      cnt       <= '0;
    end else begin
      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (!stall_i) begin
        valid_o <= valid_i;
        if (valid_i) begin
          br_flag_o <= sel.taken;
          br_way_o  <= sel_way;
          br_typ_o  <= sel.typ;
          br_tar_o  <= sel.tar;
          ras_ptr_o <= tos;
          ras_cnt_o <= cnt;
        end
      end
      if (recover_i) begin
        tos <= recover_ptr_i;
        cnt <= recover_cnt_i;
      end else if (ras_upd) begin
        case (sel.act)
          RAS_PUSH: begin
            tos <= push_slot;
            cnt <= (cnt == CNT_FULL) ? cnt : cnt + (PTR_W+1)'(1);
          end
          RAS_POP: begin
            tos <= tos - PTR_W'(1);
            cnt <= (cnt == '0) ? cnt : cnt - (PTR_W+1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // RAS entry storage; entries are never cleared, only overwritten.
  always_ff @(posedge clk_i) begin
    if (!rst_i && ras_upd) begin
      if (sel.act == RAS_PUSH) begin
        ras_stack[push_slot] <= sel.ret;
      end else if (sel.act == RAS_POPPUSH) begin
        ras_stack[tos] <= sel.ret;
      end
    end
  end

endmodule

// File: tb/tb_brdec_multi_ras.sv
// Self-checking bench for brdec_multi_ras (WAYS=4, RAS_DEPTH=8).
module tb_brdec_multi_ras;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;

  localparam logic [31:0] NOP = 32'h47FF041F;

  localparam int K_NONE = 0, K_COND = 1, K_BR = 2, K_BSR = 3,
                 K_JMP = 4, K_JSR = 5, K_RET = 6, K_COR = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               valid = 1'b0;
  logic               stall = 1'b0;
  logic               flush = 1'b0;
  logic [32*WAYS-1:0] inst = '0;
  logic [63:0]        pc = '0;
  logic [WAYS-1:0]    pred = '0;
  logic               recover = 1'b0;
  logic [PW-1:0]      rptr = '0;
  logic [PW:0]        rcnt = '0;
  logic               valid_o, br_flag_o;
  logic [2:0]         br_way_o;
  logic [1:0]         br_typ_o;
  logic [63:0]        br_tar_o;
  logic [PW-1:0]      ras_ptr_o;
  logic [PW:0]        ras_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_stack [DEPTH];
  bit          m_wr    [DEPTH];
  int          m_tos, m_cnt;
  logic        e_valid, e_flag;
  logic [2:0]  e_way;
  logic [1:0]  e_typ;
  logic [63:0] e_tar;
  int          e_ptr, e_cnt;
  bit          e_known;

  brdec_multi_ras #(.WAYS(WAYS), .RAS_DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .inst_i(inst), .pc_f1_i(pc), .pred_taken_i(pred), .recover_i(recover),
    .recover_ptr_i(rptr), .recover_cnt_i(rcnt), .valid_o(valid_o),
    .br_flag_o(br_flag_o), .br_way_o(br_way_o), .br_typ_o(br_typ_o),
    .br_tar_o(br_tar_o), .ras_ptr_o(ras_ptr_o), .ras_cnt_o(ras_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_b(input logic [5:0] op, input logic [20:0] d);
    return {op, 5'd0, d};
  endfunction

  function automatic logic [31:0] enc_j(input logic [1:0] k, input logic [13:0] d);
    return {6'h1A, 10'd0, k, d};
  endfunction

  function automatic int classify(input logic [31:0] i);
    if (i[31:29] == 3'b111) return K_COND;
    if (i[31:26] == 6'h30) return K_BR;
    if (i[31:26] == 6'h34) return K_BSR;
    if (i[31:26] == 6'h1A) return K_JMP + int'(i[15:14]);
    return K_NONE;
  endfunction

  function automatic bit is_taken(input int k, input logic [31:0] i, input logic p);
    if (k == K_NONE) return 1'b0;
`ifdef BRDEC_COND_PRED_EN
    if (k == K_COND) return p;
`else
    if (k == K_COND) return i[20];
`endif
    return 1'b1;
  endfunction

  // One clock edge of the behavioural model, using the inputs currently driven.
  task automatic model_edge();
    int sel, k;
    logic [31:0] ins;
    logic [63:0] wpc, ret, tar;
    longint d;
    if (rst) begin
      m_tos = 0; m_cnt = 0;
      e_valid = 0; e_flag = 0; e_way = 0; e_typ = 0; e_tar = 0;
      e_ptr = 0; e_cnt = 0; e_known = 1;
      return;
    end
    sel = -1; k = K_NONE;
    for (int w = 0; w < int'(WAYS); w++) begin
      ins = inst[32*w +: 32];
      if (sel < 0 && is_taken(classify(ins), ins, pred[w])) sel = w;
    end
    ins = '0; wpc = '0; ret = '0; tar = '0;
    if (sel >= 0) begin
      ins = inst[32*sel +: 32];
      k   = classify(ins);
      wpc = pc + 64'(4*sel);
      ret = wpc + 64'd4;
      if (k <= K_BSR) begin
        d = longint'($signed(ins[20:0]));
        tar = ret + 64'(d * 4);
      end else if (k <= K_JSR) begin
        d = longint'($signed(ins[13:0]));
        tar = ret + 64'(d * 4);
      end else begin
        tar = m_stack[m_tos];
      end
    end
    if (flush) begin
      e_valid = 0;
    end else if (!stall) begin
      e_valid = valid;
      if (valid) begin
        e_ptr   = m_tos;
        e_cnt   = m_cnt;
        e_flag  = (sel >= 0);
        e_way   = (sel >= 0) ? 3'(sel) : 3'd0;
        e_typ   = (k == K_NONE || k == K_COND) ? 2'd0 :
                  (k <= K_BSR) ? 2'd1 : (k <= K_JSR) ? 2'd2 : 2'd3;
        e_tar   = tar;
        e_known = !(k >= K_RET && !m_wr[m_tos]);
      end
    end
    if (recover) begin
      m_tos = int'(rptr);
      m_cnt = int'(rcnt);
    end else if (valid && !stall && !flush && sel >= 0) begin
      if (k == K_BSR || k == K_JSR) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_stack[m_tos] = ret;
        m_wr[m_tos] = 1;
        m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : m_cnt;
      end else if (k == K_RET) begin
        m_tos = (m_tos + DEPTH - 1) % DEPTH;
        m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      end else if (k == K_COR) begin
        m_stack[m_tos] = ret;
        m_wr[m_tos] = 1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_model(input int cyc);
    string s;
    s = $sformatf("@%0d", cyc);
    check({"valid", s}, 64'(valid_o), 64'(e_valid));
    check({"flag", s}, 64'(br_flag_o), 64'(e_flag));
    check({"way", s}, 64'(br_way_o), 64'(e_way));
    check({"typ", s}, 64'(br_typ_o), 64'(e_typ));
    if (e_known) check({"tar", s}, br_tar_o, e_tar);
    check({"ptr", s}, 64'(ras_ptr_o), 64'(e_ptr));
    check({"cnt", s}, 64'(ras_cnt_o), 64'(e_cnt));
  endtask

  task automatic blk(input logic [63:0] p, input logic [127:0] ins);
    pc = p; inst = ins; valid = 1; pred = '0;
  endtask

  task automatic do_reset();
    rst = 1; valid = 0; stall = 0; flush = 0; recover = 0;
    step();
    rst = 0;
  endtask

  function automatic logic [127:0] rand_block();
    logic [127:0] b;
    logic [31:0] x;
    for (int w = 0; w < int'(WAYS); w++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: x = NOP;
        3, 4:    x = {3'b111, 3'($urandom), 5'($urandom), 21'($urandom)};
        5:       x = {6'h30, 5'($urandom), 21'($urandom)};
        6:       x = {6'h34, 5'($urandom), 21'($urandom)};
        default: x = {6'h1A, 10'($urandom), 2'($urandom), 14'($urandom)};
      endcase
      b[32*w +: 32] = x;
    end
    return b;
  endfunction

  typedef struct {
    logic [63:0]  pc;
    logic [127:0] ins;
    logic [3:0]   pred;
    logic         flag;
    logic [2:0]   way;
    logic [1:0]   typ;
    logic [63:0]  tar;
  } vec_t;

  vec_t vt [8];

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_wr[i] = 0;
      m_stack[i] = '0;
    end

    // Single-block decode vectors, each starting from a reset RAS
    vt[0] = '{64'h1000, {NOP, NOP, NOP, NOP}, 4'b0000, 1'b0, 3'd0, 2'd0, 64'h0};
    vt[1] = '{64'h1000, {NOP, NOP, NOP, enc_b(6'h39, 21'h1FFFFE)}, 4'b0001,
              1'b1, 3'd0, 2'd0, 64'hFFC};
    vt[2] = '{64'h2000, {NOP, enc_b(6'h34, 21'h10), enc_b(6'h30, 21'h1FFFFF),
              enc_b(6'h38, 21'h5)}, 4'b0000, 1'b1, 3'd1, 2'd1, 64'h2004};
    vt[3] = '{64'h3000, {NOP, enc_j(2'b00, 14'h10), NOP, NOP}, 4'b0000,
              1'b1, 3'd2, 2'd2, 64'h304C};
    vt[4] = '{64'h4000, {enc_j(2'b01, 14'h3FFF), NOP, NOP, NOP}, 4'b0000,
              1'b1, 3'd3, 2'd2, 64'h400C};
    vt[5] = '{64'h0100_0000, {NOP, NOP, enc_b(6'h3F, 21'h100000), enc_b(6'h3A, 21'h3)},
              4'b0010, 1'b1, 3'd1, 2'd0, 64'hC0_0008};
    vt[6] = '{64'hFFFF_FFFF_FFFF_FFF0, {enc_b(6'h30, 21'h3), NOP, NOP, NOP}, 4'b0000,
              1'b1, 3'd3, 2'd1, 64'hC};
    vt[7] = '{64'h0, {NOP, NOP, enc_b(6'h30, 21'h0FFFFF), NOP}, 4'b0000,
              1'b1, 3'd1, 2'd1, 64'h40_0004};

    do_reset();
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_flag", 64'(br_flag_o), 64'd0);
    check("reset_tar", br_tar_o, 64'd0);
    check("reset_cnt", 64'(ras_cnt_o), 64'd0);
    check("reset_ptr", 64'(ras_ptr_o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      blk(vt[i].pc, vt[i].ins);
      pred = vt[i].pred;
      step();
      valid = 0;
      check($sformatf("vec%0d_valid", i), 64'(valid_o), 64'd1);
      check($sformatf("vec%0d_flag", i), 64'(br_flag_o), 64'(vt[i].flag));
      check($sformatf("vec%0d_way", i), 64'(br_way_o), 64'(vt[i].way));
      check($sformatf("vec%0d_typ", i), 64'(br_typ_o), 64'(vt[i].typ));
      check($sformatf("vec%0d_tar", i), br_tar_o, vt[i].tar);
      check($sformatf("vec%0d_cnt", i), 64'(ras_cnt_o), 64'd0);
    end

    // First-taken: later BSR must not push
    do_reset();
    blk(vt[2].pc, vt[2].ins);
    step();
    blk(64'h9000, {NOP, NOP, NOP, NOP});
    step();
    check("first_taken_nopush_cnt", 64'(ras_cnt_o), 64'd0);

    // BSR then RET
    do_reset();
    blk(64'h1000, {NOP, NOP, enc_b(6'h34, 21'h10), NOP});
    step();
    check("bsr_typ", 64'(br_typ_o), 64'd1);
    check("bsr_tar", br_tar_o, 64'h1048);
    check("bsr_cnt", 64'(ras_cnt_o), 64'd0);
    blk(64'h2000, {NOP, NOP, NOP, enc_j(2'b10, 14'h0)});
    step();
    check("ret_tar", br_tar_o, 64'h1008);
    check("ret_typ", 64'(br_typ_o), 64'd3);
    check("ret_cnt", 64'(ras_cnt_o), 64'd1);
    blk(64'h2100, {NOP, NOP, NOP, NOP});
    step();
    check("after_ret_cnt", 64'(ras_cnt_o), 64'd0);

    // Overflow wrap: 10 pushes, 8 pops, then a stale pop
    do_reset();
    for (int i = 0; i < 10; i++) begin
      blk(64'h10000 + 64'(256*i), {NOP, NOP, NOP, enc_b(6'h34, 21'h0)});
      step();
      check($sformatf("ovf_push%0d_cnt", i), 64'(ras_cnt_o), 64'((i < 8) ? i : 8));
    end
    for (int k = 0; k < 8; k++) begin
      blk(64'h20000, {NOP, NOP, NOP, enc_j(2'b10, 14'h0)});
      step();
      check($sformatf("ovf_ret%0d_tar", k), br_tar_o, 64'h10004 + 64'(256*(9-k)));
      check($sformatf("ovf_ret%0d_cnt", k), 64'(ras_cnt_o), 64'(8-k));
    end
    step();
    check("ovf_stale_tar", br_tar_o, 64'h10904);
    check("ovf_stale_cnt", 64'(ras_cnt_o), 64'd0);
    blk(64'h20000, {NOP, NOP, NOP, NOP});
    step();
    check("ovf_empty_cnt", 64'(ras_cnt_o), 64'd0);

    // Stall and flush
    do_reset();
    blk(64'h5000, {NOP, NOP, NOP, enc_b(6'h30, 21'h0)});
    step();
    check("pre_stall_tar", br_tar_o, 64'h5004);
    blk(64'h6000, {NOP, NOP, NOP, enc_j(2'b01, 14'h8)});
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d_valid", c), 64'(valid_o), 64'd1);
      check($sformatf("stall%0d_tar", c), br_tar_o, 64'h5004);
      check($sformatf("stall%0d_typ", c), 64'(br_typ_o), 64'd1);
      check($sformatf("stall%0d_cnt", c), 64'(ras_cnt_o), 64'd0);
    end
    stall = 0;
    step();
    check("release_tar", br_tar_o, 64'h6024);
    check("release_typ", 64'(br_typ_o), 64'd2);
    check("release_cnt", 64'(ras_cnt_o), 64'd0);
    blk(64'h7000, {NOP, NOP, NOP, enc_b(6'h34, 21'h0)});
    flush = 1;
    step();
    check("flush_valid", 64'(valid_o), 64'd0);
    stall = 1;
    step();
    check("flush_over_stall_valid", 64'(valid_o), 64'd0);
    stall = 0; flush = 0;
    blk(64'h7100, {NOP, NOP, NOP, NOP});
    step();
    check("post_flush_cnt", 64'(ras_cnt_o), 64'd1);
    check("post_flush_valid", 64'(valid_o), 64'd1);

    // Recover with a same-cycle accepted BSR
    do_reset();
    for (int i = 0; i < 5; i++) begin
      blk(64'h8000 + 64'(16*i), {NOP, NOP, NOP, enc_b(6'h34, 21'h0)});
      step();
    end
    recover = 1; rptr = 3'd2; rcnt = 4'd2;
    step();
    recover = 0;
    blk(64'h8800, {NOP, NOP, NOP, NOP});
    step();
    check("recover_ptr", 64'(ras_ptr_o), 64'd2);
    check("recover_cnt", 64'(ras_cnt_o), 64'd2);

    // Coroutine swaps the top in place
    do_reset();
    blk(64'h3FFC, {NOP, NOP, NOP, enc_b(6'h34, 21'h0)});
    step();
    blk(64'h3000, {enc_j(2'b11, 14'h0), NOP, NOP, NOP});
    step();
    check("cor_tar", br_tar_o, 64'h4000);
    check("cor_way", 64'(br_way_o), 64'd3);
    check("cor_typ", 64'(br_typ_o), 64'd3);
    check("cor_cnt", 64'(ras_cnt_o), 64'd1);
    blk(64'h9000, {NOP, NOP, NOP, enc_j(2'b10, 14'h0)});
    step();
    check("cor_top_tar", br_tar_o, 64'h3010);
    check("cor_top_cnt", 64'(ras_cnt_o), 64'd1);

    // Reset wins over stall, flush and recover
    stall = 1; flush = 1; recover = 1; rptr = 3'd5; rcnt = 4'd5; rst = 1;
    step();
    rst = 0; stall = 0; flush = 0; recover = 0;
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_tar", br_tar_o, 64'd0);
    check("midrst_typ", 64'(br_typ_o), 64'd0);
    valid = 0;
    step();
    check("midrst_cnt", 64'(ras_cnt_o), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 99) < 2);
      valid   = ($urandom_range(0, 9) < 8);
      stall   = ($urandom_range(0, 9) < 2);
      flush   = ($urandom_range(0, 9) < 1);
      recover = ($urandom_range(0, 19) < 1);
      rptr    = PW'($urandom_range(0, DEPTH-1));
      rcnt    = (PW+1)'($urandom_range(0, DEPTH));
      pred    = WAYS'($urandom);
      pc      = {$urandom, $urandom[31:2], 2'b00};
      inst    = rand_block();
      step();
      compare_model(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
